ysyx_201979054_axi_burst_ctrl: RTL and testbench
================================================

# ysyx_201979054_axi_burst_ctrl

Cache-line transfer controller that moves one line of BEATS words between the cache and memory. It issues BEATS consecutive single-beat AXI4-Lite transactions, either reads (line fill) or writes (writeback), and sits directly upstream of the AXI4-Lite interconnect. It owns its own beat count. It returns the filled line, or confirms writeback, with a one-cycle done pulse.

## Interface
- AXI_ADDR_W, 32, address width.
- AXI_DATA_W, 32, data width per beat; byte-addressed; 8·2^k.
- BEATS, 16, words per line; power of two, ≥2.
- clk  in  1  clock; all logic on the rising edge.
- arst  in  1  reset; synchronous, active-high.
- i_start_rd  in  1  start a line fill; sampled in IDLE only.
- i_start_wr  in  1  start a writeback; sampled in IDLE only.
- i_base_addr  in  AXI_ADDR_W  line address; captured at start.
- i_wr_line  in  BEATS·AXI_DATA_W  writeback line; word 0 in the LSBs; captured at start.
- o_rd_line  out  BEATS·AXI_DATA_W  filled line; valid when o_done is high after a read.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  a non-OKAY response was seen in the last burst; cleared at the next accepted start.
- AXI4-Lite master signals, all with standard meaning:
  - araddr/arvalid/arready
  - rdata/rresp/rvalid/rready
  - awaddr/awvalid/awready
  - wdata/wstrb/wvalid/wready
  - bresp/bvalid/bready
  - arprot and awprot are tied to 3'b000.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - i_start_rd → RD_ADDR.
  - Else i_start_wr → WR_REQ.
  - Simultaneous starts: the read wins; the write is dropped.
  - Starts outside IDLE are ignored.
- Start capture:
  - base = i_base_addr with its low log2(BEATS·AXI_DATA_W/8) bits forced to 0.
  - Beat count cnt = 0.
  - o_err is cleared.
  - For a write, i_wr_line is loaded into the line buffer.
- Beat address = base + cnt·(AXI_DATA_W/8).
- cnt is $clog2(BEATS) bits and is never incremented past BEATS-1.
- RD_ADDR:
  - arvalid = 1.
  - On arready → RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, rdata is stored in buffer word cnt.
  - If cnt == BEATS-1 → DONE; else cnt+1 and → RD_ADDR.
- WR_REQ:
  - awvalid and wvalid are each asserted until their own handshake; two flags track completion.
  - wdata = buffer word cnt; wstrb = all ones.
  - Once both handshakes are done (same cycle or different cycles) → WR_RESP, and the flags clear.
- WR_RESP:
  - bready = 1.
  - On bvalid: if cnt == BEATS-1 → DONE; else cnt+1 and → WR_REQ.
- Responses: rresp or bresp != 2'b00 sets o_err. Without the macro the burst still completes all BEATS beats.
- DONE:
  - o_done = 1 for one cycle, then → IDLE.
  - o_rd_line is held until the next start.
- At most one transaction is outstanding.
- Once asserted, a VALID is never dropped before its READY, and the address/data stay stable while VALID is high.
- Reset values: state IDLE, cnt 0, line buffer 0, all flags 0. All of these go to their reset values at the next edge with arst high, including mid-burst. The resulting output values are:
  - o_busy = 0, o_done = 0, o_err = 0.
  - o_rd_line = 0.
  - All valid/ready outputs = 0.

## Timing
- All outputs are decoded from registered state or flags; there is no combinational path from an input to an output.
- A start sampled at edge 0 puts arvalid or awvalid high in cycle 1.
- Zero-wait slave, read: one AR cycle plus one R cycle per beat. o_done is high in cycle 2·BEATS+1 (cycle 33 at defaults).
- Zero-wait slave, write: WR_REQ plus WR_RESP per beat, same 2·BEATS+1.
- READY asserted before VALID is legal. It is only counted in a cycle where VALID is also high.
- o_busy falls in the cycle after o_done.

## Configuration
- BURST_ABORT_ON_ERR_EN defined:
  - The first non-OKAY response ends the burst after that beat's handshake → DONE, with o_err high during o_done.
  - Words not yet transferred keep their old buffer value.
- Macro undefined: every burst runs all BEATS beats regardless of the responses.

## Structure
- Package ysyx_201979054_axi_pkg holds:
  - t_burst_state enum.
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - Default widths.
- Sub-module ysyx_201979054_line_buffer holds the BEATS×AXI_DATA_W register array, with three operations:
  - Synchronous load of the full line.
  - Write of a single word at an index.
  - Read of a single word at an index, combinational.
  - It exposes the full line as output.
- The FSM, beat counter and handshake flags stay in the top module.

## Test plan
- Read, zero-wait slave, base 0x1000_0037:
  - araddr sequence 0x1000_0000, 0x1000_0004 … 0x1000_003C.
  - rdata = 0xA0+i gives o_rd_line word i = 0xA0+i.
  - o_done in cycle 33.
- Write, random awready/wready delays of 0–3 cycles, including wready before awready:
  - 16 beats, wdata word i = i_wr_line word i.
  - VALIDs stay stable until READY; one B per beat.
  - o_done exactly once.
- Simultaneous i_start_rd and i_start_wr: only arvalid rises; no aw/w activity for the whole burst.
- bresp = 2'b10 on beat 5:
  - Without the macro: 16 beats, o_err = 1 at o_done.
  - With BURST_ABORT_ON_ERR_EN: done after beat 5, o_err = 1.
- arst asserted during beat 7 of a read:
  - Next cycle: all valid/ready outputs 0, o_busy 0, o_rd_line 0.
  - A fresh start restarts at the base address with cnt 0.
- i_start_rd pulsed while o_busy = 1: ignored; the current burst is unaffected; no extra o_done.

Source files
------------

// File: rtl/ysyx_201979054_axi_pkg.sv
// Shared types and constants for the cache-line AXI4-Lite burst controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ysyx_201979054_axi_pkg;

  localparam int DEF_AXI_ADDR_W = 32;
  localparam int DEF_AXI_DATA_W = 32;
  localparam int DEF_BEATS      = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_DONE
  } t_burst_state;

  // Anything other than OKAY counts as a failed beat for o_err.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_201979054_line_buffer.sv
// Line buffer: BEATS words of DATA_W, whole-line load or single-word write, combinational word read.
// Latency: writes/loads visible the cycle after the edge; reads are combinational.
// Backpressure: none; load has priority over word write.
// Ports: clk/arst (sync, active-high); load/load_line; wr/wr_idx/wr_word;
//        rd_idx/rd_word; line (full contents, word 0 in the LSBs).
module ysyx_201979054_line_buffer #(
  parameter int DATA_W = 32,
  parameter int BEATS  = 16
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       load,
  input  logic [BEATS*DATA_W-1:0]    load_line,
  input  logic                       wr,
  input  logic [$clog2(BEATS)-1:0]   wr_idx,
  input  logic [DATA_W-1:0]          wr_word,
  input  logic [$clog2(BEATS)-1:0]   rd_idx,
  output logic [DATA_W-1:0]          rd_word,
  output logic [BEATS*DATA_W-1:0]    line
);

  logic [DATA_W-1:0] words [BEATS];

  always_ff @(posedge clk) begin
    if (arst) begin
      for (int i = 0; i < BEATS; i++) words[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < BEATS; i++) words[i] <= load_line[i*DATA_W +: DATA_W];
    end else if (wr) begin
      words[wr_idx] <= wr_word;
    end
  end

  assign rd_word = words[rd_idx];

  always_comb begin
    line = '0;
    for (int i = 0; i < BEATS; i++) line[i*DATA_W +: DATA_W] = words[i];
  end

endmodule

// File: rtl/ysyx_201979054_axi_burst_ctrl.sv
// Cache-line transfer controller: BEATS single-beat AXI4-Lite reads (fill) or writes (writeback).
// Latency: zero-wait slave gives o_done in cycle 2*BEATS+1 after the start edge; o_done lasts one cycle.
// Backpressure: one transaction outstanding; VALIDs held with stable payload until READY.
// Ports: clk, arst (sync, active-high); i_start_rd/i_start_wr/i_base_addr/i_wr_line;
//        o_rd_line/o_busy/o_done/o_err; AXI4-Lite master AR/R/AW/W/B channels.
// Option: define BURST_ABORT_ON_ERR_EN to end a burst at the first non-OKAY response.
module ysyx_201979054_axi_burst_ctrl
  import ysyx_201979054_axi_pkg::*;
#(
  parameter int AXI_ADDR_W = DEF_AXI_ADDR_W,
  parameter int AXI_DATA_W = DEF_AXI_DATA_W,
  parameter int BEATS      = DEF_BEATS
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          i_start_rd,
  input  logic                          i_start_wr,
  input  logic [AXI_ADDR_W-1:0]         i_base_addr,
  input  logic [BEATS*AXI_DATA_W-1:0]   i_wr_line,
  output logic [BEATS*AXI_DATA_W-1:0]   o_rd_line,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  output logic [AXI_ADDR_W-1:0]         araddr,
  output logic [2:0]                    arprot,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [AXI_DATA_W-1:0]         rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rvalid,
  output logic                          rready,
  output logic [AXI_ADDR_W-1:0]         awaddr,
  output logic [2:0]                    awprot,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [AXI_DATA_W-1:0]         wdata,
  output logic [AXI_DATA_W/8-1:0]       wstrb,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int BSH   = $clog2(AXI_DATA_W/8);
  localparam int OFF_W = $clog2(BEATS*AXI_DATA_W/8);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BEATS-1);
  localparam logic [AXI_ADDR_W-1:0] OFF_MASK = AXI_ADDR_W'((64'd1 << OFF_W) - 64'd1);

`ifdef BURST_ABORT_ON_ERR_EN
  localparam bit ABORT_ON_ERR = 1'b1;
`else
  localparam bit ABORT_ON_ERR = 1'b0;
`endif

  t_burst_state state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [AXI_ADDR_W-1:0] base;
  logic [AXI_ADDR_W-1:0] beat_addr;
  logic                  aw_done, w_done, err;
  logic                  start_cap, buf_load, buf_wr, cnt_inc, hs_clr, err_set;
  logic                  aw_fire, w_fire, last_beat;
  logic [AXI_DATA_W-1:0] buf_word;

  assign last_beat = (cnt == CNT_LAST);
  assign beat_addr = base + (AXI_ADDR_W'(cnt) << BSH);
  assign aw_fire   = awvalid & awready;
  assign w_fire    = wvalid & wready;

  always_ff @(posedge clk) begin
    if (arst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_cap = 1'b0;
    buf_load  = 1'b0;
    buf_wr    = 1'b0;
    cnt_inc   = 1'b0;
    hs_clr    = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        // Read wins a simultaneous start; the write request is simply dropped.
        if (i_start_rd) begin
          state_nxt = S_RD_ADDR;
          start_cap = 1'b1;
        end else if (i_start_wr) begin
          state_nxt = S_WR_REQ;
          start_cap = 1'b1;
          buf_load  = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (arready) state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (rvalid) begin
          buf_wr  = 1'b1;
          err_set = resp_is_err(rresp);
          if (last_beat || (ABORT_ON_ERR && err_set)) begin
            state_nxt = S_DONE;
          end else begin
            cnt_inc   = 1'b1;
            state_nxt = S_RD_ADDR;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently; a handshake in this cycle counts
        // as done even though its flag only registers at the edge.
        if ((aw_done || aw_fire) && (w_done || w_fire)) begin
          hs_clr    = 1'b1;
          state_nxt = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (bvalid) begin
          err_set = resp_is_err(bresp);
          if (last_beat || (ABORT_ON_ERR && err_set)) begin
            state_nxt = S_DONE;
          end else begin
            cnt_inc   = 1'b1;
            state_nxt = S_WR_REQ;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      cnt     <= '0;
      base    <= '0;
      err     <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (start_cap) begin
        cnt  <= '0;
        base <= i_base_addr & ~OFF_MASK;
        err  <= 1'b0;
      end else begin
        if (cnt_inc) cnt <= cnt + CNT_W'(1);
        if (err_set) err <= 1'b1;
      end
      if (hs_clr) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
    end
  end

  ysyx_201979054_line_buffer #(
    .DATA_W (AXI_DATA_W),
    .BEATS  (BEATS)
  ) u_line_buffer (
    .clk       (clk),
    .arst      (arst),
    .load      (buf_load),
    .load_line (i_wr_line),
    .wr        (buf_wr),
    .wr_idx    (cnt),
    .wr_word   (rdata),
    .rd_idx    (cnt),
    .rd_word   (buf_word),
    .line      (o_rd_line)
  );

  // Every output is a decode of registered state, flags or buffer contents.
  assign o_busy  = (state != S_IDLE);
  assign o_done  = (state == S_DONE);
  assign o_err   = err;
  assign araddr  = beat_addr;
  assign arprot  = 3'b000;
  assign arvalid = (state == S_RD_ADDR);
  assign rready  = (state == S_RD_DATA);
  assign awaddr  = beat_addr;
  assign awprot  = 3'b000;
  assign awvalid = (state == S_WR_REQ) && !aw_done;
  assign wdata   = buf_word;
  assign wstrb   = '1;
  assign wvalid  = (state == S_WR_REQ) && !w_done;
  assign bready  = (state == S_WR_RESP);

endmodule

// File: tb/tb_ysyx_201979054_axi_burst_ctrl.sv
// Bench for the cache-line burst controller: randomised AXI4-Lite slave plus line-level model.
// Latency: n/a.
// Backpressure: slave applies random 0-3 cycle READY/VALID delays.
`timescale 1ns/1ps
module tb_ysyx_201979054_axi_burst_ctrl;

  localparam int NB = 16;
  localparam int DW = 32;
  localparam int LINE_BYTES = NB * DW / 8;
`ifdef BURST_ABORT_ON_ERR_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst;
  logic i_start_rd, i_start_wr;
  logic [31:0] i_base_addr;
  logic [NB*DW-1:0] i_wr_line, o_rd_line;
  logic o_busy, o_done, o_err;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0] arprot, awprot;
  logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0] rresp, bresp;
  logic [3:0] wstrb;

  ysyx_201979054_axi_burst_ctrl dut (
    .clk(clk), .arst(arst),
    .i_start_rd(i_start_rd), .i_start_wr(i_start_wr),
    .i_base_addr(i_base_addr), .i_wr_line(i_wr_line),
    .o_rd_line(o_rd_line), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- slave state / stimulus knobs ----------------
  bit rnd;
  int err_beat;
  logic [1:0] err_resp;
  logic [31:0] rdat_tab [NB];
  logic [31:0] ar_q[$], aw_q[$], w_q[$];
  logic [3:0] ws_q[$];
  int r_cnt, b_cnt;
  int ar_d, aw_d, w_d, r_d, b_d;
  bit ar_arm, aw_arm, w_arm, r_pend, b_pend, aw_got, w_got;

  function automatic int pick_dly();
    return rnd ? int'($urandom_range(0, 3)) : 0;
  endfunction

  always @(negedge clk) begin
    if (arst) begin
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      rdata = 0; rresp = 0; bresp = 0;
      ar_arm = 0; aw_arm = 0; w_arm = 0; r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    end else begin
      // R channel: response for the previously accepted AR
      rvalid = 0; rdata = $urandom; rresp = 2'($urandom_range(0, 3));
      if (r_pend) begin
        if (r_d == 0) begin
          rvalid = 1;
          rdata = (r_cnt < NB) ? rdat_tab[r_cnt] : 32'h0;
          rresp = (r_cnt == err_beat) ? err_resp : 2'b00;
        end else r_d--;
      end
      if (rvalid && rready) begin r_cnt++; r_pend = 0; end
      // B channel
      bvalid = 0; bresp = 2'($urandom_range(0, 3));
      if (b_pend) begin
        if (b_d == 0) begin
          bvalid = 1;
          bresp = (b_cnt == err_beat) ? err_resp : 2'b00;
        end else b_d--;
      end
      if (bvalid && bready) begin b_cnt++; b_pend = 0; end
      // AR channel (READY may also appear with no VALID)
      if (arvalid) begin
        if (!ar_arm) begin ar_arm = 1; ar_d = pick_dly(); end
        arready = (ar_d == 0);
        if (ar_d != 0) ar_d--;
      end else arready = rnd && ($urandom_range(0, 3) == 0);
      if (arvalid && arready) begin
        ar_q.push_back(araddr); ar_arm = 0; r_pend = 1; r_d = pick_dly();
      end
      // AW channel
      if (awvalid) begin
        if (!aw_arm) begin aw_arm = 1; aw_d = pick_dly(); end
        awready = (aw_d == 0);
        if (aw_d != 0) aw_d--;
      end else awready = rnd && ($urandom_range(0, 3) == 0);
      if (awvalid && awready) begin aw_q.push_back(awaddr); aw_arm = 0; aw_got = 1; end
      // W channel
      if (wvalid) begin
        if (!w_arm) begin w_arm = 1; w_d = pick_dly(); end
        wready = (w_d == 0);
        if (w_d != 0) w_d--;
      end else wready = rnd && ($urandom_range(0, 3) == 0);
      if (wvalid && wready) begin w_q.push_back(wdata); ws_q.push_back(wstrb); w_arm = 0; w_got = 1; end
      if (aw_got && w_got) begin b_pend = 1; b_d = pick_dly(); aw_got = 0; w_got = 0; end
    end
  end

  // ---------------- per-cycle compare process ----------------
  bit rst_edge = 1'b1;
  bit in_rd, in_wr;
  int done_cnt;
  logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [3:0] p_wstrb;

  always @(posedge clk) rst_edge = arst;

  always @(negedge clk) begin
    #1;
    if (!rst_edge) begin
      if (p_arv && !p_arr) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_wv && !p_wr)   chk("w_hold", {wvalid, wstrb, wdata}, {1'b1, p_wstrb, p_wdata});
    end
    if (!o_busy) chk("idle_quiet", {o_done, arvalid, rready, awvalid, wvalid, bready}, 6'b0);
    if (in_rd) chk("rd_no_wr_chan", {awvalid, wvalid, bready}, 3'b0);
    if (in_wr) chk("wr_no_rd_chan", {arvalid, rready}, 2'b0);
    if (o_done) done_cnt++;
    p_arv = arvalid; p_arr = arready; p_araddr = araddr;
    p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
    p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
  end

  // ---------------- line-level model ----------------
  logic [31:0] model_line [NB];

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    return (base / LINE_BYTES) * LINE_BYTES + 32'(i * (DW / 8));
  endfunction

  function automatic logic [NB*DW-1:0] model_packed();
    logic [NB*DW-1:0] v;
    for (int i = 0; i < NB; i++) v[i*DW +: DW] = model_line[i];
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_slave();
    ar_q.delete(); aw_q.delete(); w_q.delete(); ws_q.delete();
    r_cnt = 0; b_cnt = 0; done_cnt = 0;
  endtask

  task automatic run_burst(input bit is_rd, input bit both, input logic [31:0] base,
                           input bit rnd_i, input bit pat_a0, input int eb,
                           input logic [1:0] er, input int pulse_at, output int done_c);
    logic [31:0] wl [NB];
    int n_exp;
    bit rd;
    rd = is_rd || both;
    rnd = rnd_i; err_beat = eb; err_resp = er;
    for (int i = 0; i < NB; i++) begin
      rdat_tab[i] = pat_a0 ? 32'hA0 + 32'(i) : $urandom;
      wl[i] = $urandom;
      i_wr_line[i*DW +: DW] = wl[i];
    end
    clear_slave();
    n_exp = (ABORT && eb >= 0) ? eb + 1 : NB;
    i_base_addr = base;
    i_start_rd = rd;
    i_start_wr = !is_rd || both;
    in_rd = rd; in_wr = !rd;
    done_c = 0;
    for (int c = 1; c <= 3000 && done_c == 0; c++) begin
      tick();
      if (c == 1) begin
        i_start_rd = 0; i_start_wr = 0;
        i_base_addr = $urandom;
        for (int i = 0; i < NB; i++) i_wr_line[i*DW +: DW] = $urandom;
        chk("c1_busy", o_busy, 1'b1);
        chk("c1_err_cleared", o_err, 1'b0);
        chk("c1_first_valid", rd ? arvalid : awvalid, 1'b1);
      end
      if (pulse_at > 1 && c == pulse_at) begin i_start_rd = 1; i_start_wr = 1; end
      else if (pulse_at > 1 && c == pulse_at + 1) begin i_start_rd = 0; i_start_wr = 0; end
      if (o_done) done_c = c;
    end
    if (done_c == 0) begin
      chk("done_seen", o_done, 1'b1);
    end else begin
      if (!rnd_i) chk("done_cycle", done_c, 2 * n_exp + 1);
      chk("err_at_done", o_err, eb >= 0);
      if (rd) begin
        chk("ar_count", ar_q.size(), n_exp);
        chk("r_count", r_cnt, n_exp);
        chk("aw_none", aw_q.size() + w_q.size(), 0);
        for (int i = 0; i < n_exp && i < ar_q.size(); i++) chk("araddr", ar_q[i], exp_addr(base, i));
        for (int i = 0; i < n_exp; i++) model_line[i] = rdat_tab[i];
        chk("rd_line", o_rd_line, model_packed());
      end else begin
        for (int i = 0; i < NB; i++) model_line[i] = wl[i];
        chk("aw_count", aw_q.size(), n_exp);
        chk("w_count", w_q.size(), n_exp);
        chk("b_count", b_cnt, n_exp);
        chk("ar_none", ar_q.size(), 0);
        for (int i = 0; i < n_exp && i < aw_q.size(); i++) chk("awaddr", aw_q[i], exp_addr(base, i));
        for (int i = 0; i < n_exp && i < w_q.size(); i++) begin
          chk("wdata", w_q[i], wl[i]);
          chk("wstrb", ws_q[i], 4'hF);
        end
      end
      tick();
      chk("busy_after_done", o_busy, 1'b0);
      chk("done_low_after", o_done, 1'b0);
      chk("done_once", done_cnt, 1);
      if (rd) chk("rd_line_held", o_rd_line, model_packed());
    end
    in_rd = 0; in_wr = 0;
  endtask

  int dc;

  initial begin
    arst = 1; i_start_rd = 0; i_start_wr = 0; i_base_addr = 0; i_wr_line = '0;
    rnd = 0; err_beat = -1; err_resp = 2'b00; in_rd = 0; in_wr = 0;
    for (int i = 0; i < NB; i++) model_line[i] = 32'h0;
    clear_slave();
    repeat (3) tick();
    chk("rst_outputs", {o_busy, o_done, o_err, arvalid, rready, awvalid, wvalid, bready}, 8'b0);
    chk("rst_line", o_rd_line, '0);
    chk("rst_prot", {arprot, awprot}, 6'b0);
    arst = 0;
    tick();

    // Zero-wait read with literal pins on address, data and timing.
    run_burst(1, 0, 32'h1000_0037, 0, 1, -1, 2'b00, 0, dc);
    chk("lit_done_33", dc, 33);
    chk("lit_araddr0", ar_q[0], 32'h1000_0000);
    chk("lit_araddr15", ar_q[15], 32'h1000_003C);
    chk("lit_word3", o_rd_line[3*32 +: 32], 32'hA3);
    chk("lit_word15", o_rd_line[15*32 +: 32], 32'hAF);

    // Writes: random handshake delays, then zero-wait.
    run_burst(0, 0, $urandom, 1, 0, -1, 2'b00, 0, dc);
    run_burst(0, 0, 32'h8000_0F44, 0, 0, -1, 2'b00, 0, dc);
    chk("lit_wr_done_33", dc, 33);

    // Simultaneous starts: read only.
    run_burst(0, 1, $urandom, 1, 0, -1, 2'b00, 0, dc);

    // SLVERR on write beat 5.
    run_burst(0, 0, 32'h0000_1200, 0, 0, 5, 2'b10, 0, dc);
    chk("lit_err_done", dc, ABORT ? 13 : 33);

    // Start pulsed while busy is ignored.
    run_burst(1, 0, $urandom, 1, 0, -1, 2'b00, 10, dc);

    // DECERR on read beat 9 with random delays; next burst must clear o_err.
    run_burst(1, 0, $urandom, 1, 0, 9, 2'b11, 0, dc);
    run_burst(0, 0, $urandom, 1, 0, -1, 2'b00, 0, dc);

    // Reset during beat 7 of a read, then a fresh read from the same base.
    rnd = 0; err_beat = -1;
    clear_slave();
    i_base_addr = 32'h2000_0140; i_start_rd = 1; in_rd = 1;
    tick();
    i_start_rd = 0;
    for (int c = 0; c < 200 && ar_q.size() < 8; c++) tick();
    chk("pre_rst_busy", o_busy, 1'b1);
    arst = 1;
    tick();
    arst = 0; in_rd = 0;
    chk("midrst_outputs", {o_busy, o_done, o_err, arvalid, rready, awvalid, wvalid, bready}, 8'b0);
    chk("midrst_line", o_rd_line, '0);
    for (int i = 0; i < NB; i++) model_line[i] = 32'h0;
    tick();
    run_burst(1, 0, 32'h2000_0140, 0, 0, -1, 2'b00, 0, dc);
    chk("lit_restart_addr", ar_q[0], 32'h2000_0140);

    // A few fully random bursts.
    for (int k = 0; k < 4; k++) begin
      run_burst(1'($urandom_range(0, 1)), 0, $urandom, 1, 0,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NB-1)) : -1,
                2'($urandom_range(1, 3)), 0, dc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
